// File: rtl/nn_smoothgrad_pkg.sv
// Shared constants and helpers for the polar gradient smoother.
package nn_smoothgrad_pkg;

  // Polarity of a pulse or of a stored magnitude.
  typedef enum logic {
    SIGN_POS = 1'b0,
    SIGN_NEG = 1'b1
  } polarity_e;

  // Largest magnitude representable in n bits (2^n-1).
  function automatic logic [63:0] N_MAX_MAG(input int unsigned n);
    return (64'd1 << n) - 64'd1;
  endfunction

  // A threshold of zero behaves like one: every qualifying pulse steps.
  function automatic logic [31:0] eff_res(input logic [31:0] r);
    return (r == '0) ? 32'd1 : r;
  endfunction

endpackage

// File: rtl/nn_smoothgrad_polar_ch.sv
// Single channel: sign-magnitude integrator with a same-polarity pulse counter.
module nn_smoothgrad_polar_ch
  import nn_smoothgrad_pkg::*;
#(
  parameter int unsigned N            = 8,
  parameter int unsigned N_RESISTANCE = 9
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    load,
  input  logic                    in_ss,
  input  logic                    sign,
  input  logic [N_RESISTANCE-1:0] resistance,
  input  logic [N-1:0]            out_init,
  input  logic                    sign_out_init,
  output logic [N-1:0]            mag,
  output logic                    sign_out,
  output logic                    sat,
  output logic                    trig
);

  localparam logic [N-1:0]            MAX_MAG = N'(N_MAX_MAG(N));
  localparam logic [N_RESISTANCE-1:0] MAX_CNT = '1;

  logic [N-1:0]            mag_q, mag_d;
  logic                    sign_q, sign_d;
  logic [N_RESISTANCE-1:0] cnt_q, cnt_d, cnt_n;
  logic                    last_q, last_d;
  logic                    sat_q, sat_d;
  logic                    trig_q, trig_d;
  logic [31:0]             eff_r;

  assign eff_r = eff_res(32'(resistance));

  // Next-state: load beats enable; a step fires when the updated count reaches eff_r.
  always_comb begin
    mag_d  = mag_q;
    sign_d = sign_q;
    cnt_d  = cnt_q;
    last_d = last_q;
    sat_d  = sat_q;
    trig_d = 1'b0;
    cnt_n  = cnt_q;
    if (load) begin
      mag_d  = out_init;
      sign_d = sign_out_init;
      cnt_d  = '0;
      sat_d  = (out_init == MAX_MAG);
    end else if (en && in_ss) begin
      if (sign != last_q) begin
        cnt_n  = N_RESISTANCE'(1);
        last_d = sign;
      end else if (cnt_q != MAX_CNT) begin
        cnt_n = cnt_q + N_RESISTANCE'(1);
      end
      cnt_d = cnt_n;
      if (32'(cnt_n) >= eff_r) begin
        cnt_d = '0;
        if (sign == sign_q) begin
          if (mag_q != MAX_MAG) mag_d = mag_q + N'(1);
        end else if (mag_q != '0) begin
          mag_d = mag_q - N'(1);
        end else begin
          mag_d  = N'(1);
          sign_d = sign;
          trig_d = 1'b1;
        end
      end
      sat_d = (mag_d == MAX_MAG);
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mag_q  <= '0;
      sign_q <= SIGN_POS;
      cnt_q  <= '0;
      last_q <= SIGN_POS;
      sat_q  <= 1'b0;
      trig_q <= 1'b0;
    end else begin
      mag_q  <= mag_d;
      sign_q <= sign_d;
      cnt_q  <= cnt_d;
      last_q <= last_d;
      sat_q  <= sat_d;
      trig_q <= trig_d;
    end
  end

  assign mag      = mag_q;
  assign sign_out = sign_q;
  assign sat      = sat_q;
  assign trig     = trig_q;

endmodule

// File: rtl/nn_smoothgrad_polar_multi.sv
// Multi-channel polar gradient smoother: N_CH independent channels on packed buses.
module nn_smoothgrad_polar_multi
  import nn_smoothgrad_pkg::*;
#(
  parameter int unsigned N_CH         = 4,
  parameter int unsigned N            = 8,
  parameter int unsigned N_RESISTANCE = 9
) (
  input  logic                    CLK,
  input  logic                    INIT_N,
  input  logic                    EN,
  input  logic                    LOAD,
  input  logic [N_CH-1:0]         IN_SS,
  input  logic [N_CH-1:0]         SIGN,
  input  logic [N_RESISTANCE-1:0] RESISTANCE,
  input  logic [N_CH*N-1:0]       OUT_INIT,
  input  logic [N_CH-1:0]         SIGN_OUT_INIT,
  output logic [N_CH*N-1:0]       OUT,
  output logic [N_CH-1:0]         SIGN_out,
  output logic [N_CH-1:0]         SAT,
  output logic [N_CH-1:0]         TransitionChange_TRIG
);

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    nn_smoothgrad_polar_ch #(
      .N            (N),
      .N_RESISTANCE (N_RESISTANCE)
    ) u_ch (
      .clk           (CLK),
      .rst_n         (INIT_N),
      .en            (EN),
      .load          (LOAD),
      .in_ss         (IN_SS[k]),
      .sign          (SIGN[k]),
      .resistance    (RESISTANCE),
      .out_init      (OUT_INIT[k*N +: N]),
      .sign_out_init (SIGN_OUT_INIT[k]),
      .mag           (OUT[k*N +: N]),
      .sign_out      (SIGN_out[k]),
      .sat           (SAT[k]),
      .trig          (TransitionChange_TRIG[k])
    );
  end

endmodule

// File: tb/tb_nn_smoothgrad_polar_multi.sv
// Self-checking bench: behavioural model compared every cycle plus directed literal checks.
module tb_nn_smoothgrad_polar_multi;

  localparam int NCH = 4;
  localparam int NB  = 8;
  localparam int NR  = 9;
  localparam int MAXM = 255;
  localparam int MAXC = 511;

  logic              CLK = 1'b0;
  logic              INIT_N;
  logic              EN, LOAD;
  logic [NCH-1:0]    IN_SS, SIGN, SIGN_OUT_INIT;
  logic [NR-1:0]     RESISTANCE;
  logic [NCH*NB-1:0] OUT_INIT;
  logic [NCH*NB-1:0] OUT;
  logic [NCH-1:0]    SIGN_out, SAT, TransitionChange_TRIG;

  int errors = 0;
  int checks = 0;

  // Model state: plain integers per channel.
  int m_mag [NCH];
  int m_sgn [NCH];
  int m_cnt [NCH];
  int m_last[NCH];
  int m_trig[NCH];

  nn_smoothgrad_polar_multi #(.N_CH(NCH), .N(NB), .N_RESISTANCE(NR)) dut (
    .CLK(CLK), .INIT_N(INIT_N), .EN(EN), .LOAD(LOAD), .IN_SS(IN_SS), .SIGN(SIGN),
    .RESISTANCE(RESISTANCE), .OUT_INIT(OUT_INIT), .SIGN_OUT_INIT(SIGN_OUT_INIT),
    .OUT(OUT), .SIGN_out(SIGN_out), .SAT(SAT),
    .TransitionChange_TRIG(TransitionChange_TRIG)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: integrate pulses into a sign/magnitude pair.
  initial begin
    for (int k = 0; k < NCH; k++) begin
      m_mag[k] = 0; m_sgn[k] = 0; m_cnt[k] = 0; m_last[k] = 0; m_trig[k] = 0;
    end
    forever begin
      @(posedge CLK or negedge INIT_N);
      for (int k = 0; k < NCH; k++) begin
        if (!INIT_N) begin
          m_mag[k] = 0; m_sgn[k] = 0; m_cnt[k] = 0; m_last[k] = 0; m_trig[k] = 0;
        end else if (LOAD) begin
          m_mag[k]  = int'(OUT_INIT[k*NB +: NB]);
          m_sgn[k]  = int'(SIGN_OUT_INIT[k]);
          m_cnt[k]  = 0;
          m_trig[k] = 0;
        end else begin
          m_trig[k] = 0;
          if (EN && IN_SS[k]) begin
            int s;
            int thr;
            s   = int'(SIGN[k]);
            thr = (RESISTANCE == 0) ? 1 : int'(RESISTANCE);
            if (s != m_last[k]) begin
              m_cnt[k]  = 1;
              m_last[k] = s;
            end else begin
              m_cnt[k] = (m_cnt[k] + 1 > MAXC) ? MAXC : m_cnt[k] + 1;
            end
            if (m_cnt[k] >= thr) begin
              m_cnt[k] = 0;
              if (s == m_sgn[k])      m_mag[k] = (m_mag[k] == MAXM) ? MAXM : m_mag[k] + 1;
              else if (m_mag[k] > 0)  m_mag[k] = m_mag[k] - 1;
              else begin
                m_mag[k]  = 1;
                m_sgn[k]  = s;
                m_trig[k] = 1;
              end
            end
          end
        end
      end
    end
  end

  // Compare all outputs against the model every cycle, away from the rising edge.
  initial begin
    forever begin
      @(negedge CLK);
      if (INIT_N === 1'b1) begin
        logic [NCH*NB-1:0] e_out;
        logic [NCH-1:0]    e_sg, e_sat, e_tr;
        for (int k = 0; k < NCH; k++) begin
          e_out[k*NB +: NB] = NB'(m_mag[k]);
          e_sg[k]  = (m_sgn[k] != 0);
          e_sat[k] = (m_mag[k] == MAXM);
          e_tr[k]  = (m_trig[k] != 0);
        end
        chk("OUT",      64'(OUT), 64'(e_out));
        chk("SIGN_out", 64'(SIGN_out), 64'(e_sg));
        chk("SAT",      64'(SAT), 64'(e_sat));
        chk("TRIG",     64'(TransitionChange_TRIG), 64'(e_tr));
      end
    end
  end

  // Present inputs right after a falling edge, return after the next falling edge.
  task automatic tick(input logic en, input logic ld, input logic [NCH-1:0] ss,
                      input logic [NCH-1:0] sg);
    EN = en; LOAD = ld; IN_SS = ss; SIGN = sg;
    @(negedge CLK);
  endtask

  initial begin
    logic seen;
    INIT_N = 1'b0; EN = 1'b0; LOAD = 1'b0; IN_SS = '0; SIGN = '0;
    RESISTANCE = 9'd1; OUT_INIT = '0; SIGN_OUT_INIT = '0;
    repeat (2) @(negedge CLK);
    chk("reset_out", 64'(OUT), 64'd0);
    chk("reset_flags", 64'({SIGN_out, SAT, TransitionChange_TRIG}), 64'd0);
    INIT_N = 1'b1;

    // ch0 counts up one LSB per pulse.
    RESISTANCE = 9'd1;
    repeat (5) tick(1, 0, 4'b0001, 4'b0000);
    chk("t1_ch0", 64'(OUT[7:0]), 64'd5);
    chk("t1_model_ch0", 64'(m_mag[0]), 64'd5);
    chk("t1_others", 64'(OUT[31:8]), 64'd0);
    chk("t1_sign0", 64'(SIGN_out[0]), 64'd0);

    // ch1 steps after every third pulse.
    RESISTANCE = 9'd3;
    for (int i = 1; i <= 7; i++) begin
      tick(1, 0, 4'b0010, 4'b0000);
      if (i == 2) chk("t2_after2", 64'(OUT[15:8]), 64'd0);
      if (i == 3) chk("t2_after3", 64'(OUT[15:8]), 64'd1);
      if (i == 6) chk("t2_after6", 64'(OUT[15:8]), 64'd2);
    end
    chk("t2_final", 64'(OUT[15:8]), 64'd2);

    // Alternating polarity on ch2 never accumulates.
    RESISTANCE = 9'd2;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick(1, 0, 4'b0100, (i % 2 == 1) ? 4'b0100 : 4'b0000);
      if (TransitionChange_TRIG[2]) seen = 1'b1;
    end
    chk("t3_ch2", 64'(OUT[23:16]), 64'd0);
    chk("t3_notrig", 64'(seen), 64'd0);

    // ch3 crosses zero: 1 -> 0 -> 1 with sign flip and a single trigger.
    OUT_INIT = 32'h0100_0000; SIGN_OUT_INIT = '0; RESISTANCE = 9'd1;
    tick(0, 1, 4'b1111, 4'b1111);
    chk("t4_load", 64'(OUT[31:24]), 64'd1);
    tick(1, 0, 4'b1000, 4'b1000);
    chk("t4_dec", 64'({SIGN_out[3], OUT[31:24]}), 64'h000);
    tick(1, 0, 4'b1000, 4'b1000);
    chk("t4_cross", 64'({SIGN_out[3], OUT[31:24]}), 64'h101);
    chk("t4_trig", 64'(TransitionChange_TRIG[3]), 64'd1);
    tick(1, 0, 4'b0000, 4'b0000);
    chk("t4_trig_clr", 64'(TransitionChange_TRIG[3]), 64'd0);

    // Saturation at 255 on ch0.
    OUT_INIT = 32'h0000_00FE; SIGN_OUT_INIT = '0;
    tick(1, 1, 4'b0000, 4'b0000);
    tick(1, 0, 4'b0001, 4'b0000);
    chk("t5_sat_val", 64'({SAT[0], OUT[7:0]}), 64'h1FF);
    repeat (2) tick(1, 0, 4'b0001, 4'b0000);
    chk("t5_sat_hold", 64'({SAT[0], OUT[7:0]}), 64'h1FF);
    tick(1, 0, 4'b0001, 4'b0001);
    chk("t5_unsat", 64'({SAT[0], OUT[7:0]}), 64'h0FE);

    // Asynchronous reset in the middle of a count.
    OUT_INIT = 32'h0000_0005; RESISTANCE = 9'd4;
    tick(0, 1, 4'b0000, 4'b0000);
    repeat (2) tick(1, 0, 4'b0001, 4'b0000);
    #2 INIT_N = 1'b0;
    #1;
    chk("t6_async_out", 64'(OUT), 64'd0);
    chk("t6_async_flags", 64'({SIGN_out, SAT, TransitionChange_TRIG}), 64'd0);
    @(negedge CLK);
    INIT_N = 1'b1;
    repeat (3) tick(1, 0, 4'b0001, 4'b0000);
    chk("t6_no_step", 64'(OUT[7:0]), 64'd0);
    tick(1, 0, 4'b0001, 4'b0000);
    chk("t6_step", 64'(OUT[7:0]), 64'd1);
    repeat (6) tick(0, 0, 4'b1111, 4'b0000);
    chk("t6_en_hold", 64'(OUT), 64'h0000_0001);

    // Randomised traffic with slowly drifting per-channel polarity.
    begin
      logic [NCH-1:0] sg;
      sg = '0;
      for (int i = 0; i < 800; i++) begin
        logic [NCH-1:0] flip;
        flip = '0;
        for (int k = 0; k < NCH; k++) begin
          flip[k] = ($urandom_range(0, 7) == 0);
          case ($urandom_range(0, 4))
            0: OUT_INIT[k*NB +: NB] = 8'd0;
            1: OUT_INIT[k*NB +: NB] = 8'd1;
            2: OUT_INIT[k*NB +: NB] = 8'd254;
            3: OUT_INIT[k*NB +: NB] = 8'd255;
            default: OUT_INIT[k*NB +: NB] = NB'($urandom);
          endcase
        end
        sg = sg ^ flip;
        SIGN_OUT_INIT = NCH'($urandom);
        if ($urandom_range(0, 19) == 0) RESISTANCE = NR'($urandom_range(0, 4));
        tick($urandom_range(0, 9) != 0, $urandom_range(0, 49) == 0,
             NCH'($urandom), sg);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/nn_smoothgrad_polar_multi.md
Name: nn_smoothgrad_polar_multi

Overview:
Multi-channel sign-magnitude (polar) gradient smoother for the stochastic NN training datapath. Each channel integrates a stochastic pulse stream IN_SS with polarity SIGN into a saturating N-bit magnitude plus sign register. The channel moves one LSB only after RESISTANCE same-polarity pulses have accumulated. It sits between the stochastic gradient generators and the weight-update logic, and replaces the fixed 8-bit single-channel smoother.

Parameters:
N_CH, 4, number of independent channels
N, 8, magnitude width per channel
N_RESISTANCE, 9, width of the resistance threshold and the per-channel pulse counter

Ports:
CLK  input  1  clock, all state updates on rising edge
INIT_N  input  1  reset, asynchronous, active-low
EN  input  1  global update enable; when low, all state holds
LOAD  input  1  synchronous load of initial values, all channels
IN_SS  input  N_CH  stochastic pulse per channel
SIGN  input  N_CH  polarity of IN_SS per channel (1 = negative)
RESISTANCE  input  N_RESISTANCE  pulses required per LSB step; shared by all channels
OUT_INIT  input  N_CH*N  load magnitudes; channel k at [k*N +: N]
SIGN_OUT_INIT  input  N_CH  load signs
OUT  output  N_CH*N  registered magnitudes; channel k at [k*N +: N]
SIGN_out  output  N_CH  registered signs
SAT  output  N_CH  registered; 1 when magnitude = 2^N-1
TransitionChange_TRIG  output  N_CH  one-cycle pulse when a channel's SIGN_out changes

Behaviour:
- Reset (INIT_N=0, asynchronous): OUT=0, SIGN_out=0, SAT=0, TransitionChange_TRIG=0, pulse counters=0, last-pulse-sign=0. The block holds this state until INIT_N deasserts; the first update is on the following edge.
- Priority per edge: reset > LOAD > EN.
- LOAD=1: OUT<=OUT_INIT, SIGN_out<=SIGN_SIGN_OUT_INIT, SAT from the loaded value, counters<=0, TransitionChange_TRIG<=0. LOAD ignores EN, and IN_SS in the same cycle is discarded.
- EN=0 and LOAD=0: every register holds, except TransitionChange_TRIG, which clears to 0.
- EN=1, per channel with IN_SS=1:
  - If SIGN differs from last-pulse-sign, the counter restarts at 1 and last-pulse-sign<=SIGN (dynamic resistance: alternating noise does not accumulate).
  - Otherwise the counter increments.
  - A step fires when the updated count >= eff_R, where eff_R = max(RESISTANCE,1). On a step the counter is set to 0.
- EN=1 with IN_SS=0: the channel holds.
- Step rules, with M = current magnitude and S = SIGN_out:
  - SIGN==S: M<=M+1, saturating at 2^N-1; at saturation, no change and no wrap.
  - SIGN!=S and M>0: M<=M-1; S is unchanged even if M reaches 0.
  - SIGN!=S and M==0: M<=1, S<=SIGN. This is a zero crossing in a single step.
- TransitionChange_TRIG[k] is 1 for exactly the cycle after the edge on which SIGN_out[k] changed by a step. LOAD never raises it.
- Latency: the pulse that completes the count updates OUT on the same edge, so it is visible one cycle after IN_SS is sampled.
- RESISTANCE change mid-count: the new value takes effect immediately. If count >= new eff_R, the next qualifying pulse steps.
- The counter saturates at 2^N_RESISTANCE-1 and never wraps.
- Channels are fully independent; simultaneous steps on all channels are legal.
- All arithmetic is unsigned at N bits, with explicit saturation; no sign-extended math.

Decomposition:
- Shared package nn_smoothgrad_pkg holds:
  - N_MAX_MAG function (2^N-1)
  - effective-resistance function max(R,1)
  - SIGN_POS=0 and SIGN_NEG=1 constants
- One sub-module, nn_smoothgrad_polar_ch: the single-channel magnitude, sign, counter, last-sign, SAT and trigger logic.
- The top level generates N_CH instances and packs the buses.

Test Plan:
- Reset then RESISTANCE=1, ch0 SIGN=0, IN_SS=1 for 5 cycles -> OUT[7:0]=5 and SIGN_out[0]=0; other channels stay 0.
- RESISTANCE=3, ch1 SIGN=0 pulses on 7 cycles -> OUT ch1 increments after the 3rd and 6th pulses, final value 2.
- RESISTANCE=2, ch2 pulses with alternating SIGN 0,1,0,1 for 8 cycles -> ch2 stays 0 and TransitionChange_TRIG[2] never fires.
- LOAD ch3 OUT_INIT=1, SIGN_OUT_INIT=0; RESISTANCE=1; two SIGN=1 pulses -> OUT=0 with SIGN_out=0, then OUT=1 with SIGN_out=1; TransitionChange_TRIG[3] high for exactly one cycle.
- LOAD OUT_INIT=254, RESISTANCE=1, 3 same-sign pulses -> 255, SAT=1, value holds at 255; one opposite pulse -> 254, SAT=0.
- Mid-count (count=2 of 4), drive INIT_N low asynchronously between edges -> all outputs 0 immediately; after release, 4 pulses are needed for the first step. Repeat with EN=0 during pulses -> no state change.
